// File: rtl/mips_pkg.sv
// MIPS-I opcode/funct encodings shared by the execute datapath and the CPU control FSM.
// Pure declarations: no logic, no latency, no flow control.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_N     = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDI    = 6'h08,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_COP0    = 6'h10,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'h00,
    FN_SRL   = 6'h02,
    FN_SRA   = 6'h03,
    FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06,
    FN_SRAV  = 6'h07,
    FN_JR    = 6'h08,
    FN_JALR  = 6'h09,
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B,
    FN_ADD   = 6'h20,
    FN_ADDU  = 6'h21,
    FN_SUB   = 6'h22,
    FN_SUBU  = 6'h23,
    FN_AND   = 6'h24,
    FN_OR    = 6'h25,
    FN_XOR   = 6'h26,
    FN_NOR   = 6'h27,
    FN_SLT   = 6'h2A,
    FN_SLTU  = 6'h2B
  } funct_t;

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port committed on the clk edge.
// Reads have zero latency with no write bypass; no backpressure, a write is always accepted.
module mips_regfile
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs_index,
  input  logic [REG_IDX_W-1:0] rt_index,
  input  logic [REG_IDX_W-1:0] write_index,
  input  logic                 write_enable,
  input  logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic [DATA_W-1:0]    register_v0
);

  logic [DATA_W-1:0] regs [REG_N];

  // regs[0] is only ever cleared, so it reads as the hardwired zero register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (write_index != '0)) begin
      regs[write_index] <= write_data;
    end
  end

  assign rs_data     = regs[rs_index];
  assign rt_data     = regs[rt_index];
  assign register_v0 = regs[2];

endmodule

// File: rtl/mips_alu_regfile.sv
// Execute-stage datapath: register file plus combinational ALU, branch test and carry/zero flags.
// ALU and flags are zero-latency from the read ports; no backpressure, driven every cycle by the FSM.
module mips_alu_regfile
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [4:0]           shamt,
  input  logic [15:0]          imm,
  input  logic [REG_IDX_W-1:0] rs_index,
  input  logic [REG_IDX_W-1:0] rt_index,
  input  logic [REG_IDX_W-1:0] write_index,
  input  logic                 write_enable,
  input  logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic [DATA_W-1:0]    alu_out,
  output logic                 branch,
  output logic                 carry_out,
  output logic                 zero,
  output logic [DATA_W-1:0]    register_v0
);

  mips_regfile u_regfile (
    .clk          (clk),
    .reset        (reset),
    .rs_index     (rs_index),
    .rt_index     (rt_index),
    .write_index  (write_index),
    .write_enable (write_enable),
    .write_data   (write_data),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .register_v0  (register_v0)
  );

  opcode_t            op;
  funct_t             fn;
  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic [DATA_W-1:0]  se;
  logic [DATA_W-1:0]  ze;
  logic [DATA_W:0]    sum_ab;
  logic [DATA_W:0]    diff_ab;
  logic [DATA_W:0]    sum_ai;
  logic [DATA_W-1:0]  sum_as;
  logic               lt_ab_s;
  logic               lt_ai_s;
  logic               lt_ai_u;
  logic signed [DATA_W-1:0] sra_imm;
  logic signed [DATA_W-1:0] sra_var;

  assign op = opcode_t'(opcode);
  assign fn = funct_t'(funct);
  assign a  = rs_data;
  assign b  = rt_data;
  assign se = sign_ext16(imm);
  assign ze = {16'h0000, imm};

  // 33-bit forms expose carry and borrow directly in the top bit.
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_ai  = {1'b0, a} + {1'b0, se};
  assign sum_as  = sum_ai[DATA_W-1:0];

  assign lt_ab_s = $signed(a) < $signed(b);
  assign lt_ai_s = $signed(a) < $signed(se);
  assign lt_ai_u = a < se;
  assign sra_imm = $signed(b) >>> shamt;
  assign sra_var = $signed(b) >>> a[4:0];

  always_comb begin
    alu_out   = '0;
    branch    = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL:  alu_out = b << shamt;
          FN_SRL:  alu_out = b >> shamt;
          FN_SRA:  alu_out = sra_imm;
          FN_SLLV: alu_out = b << a[4:0];
          FN_SRLV: alu_out = b >> a[4:0];
          FN_SRAV: alu_out = sra_var;
          FN_ADD, FN_ADDU: begin
            alu_out   = sum_ab[DATA_W-1:0];
            carry_out = sum_ab[DATA_W];
          end
          FN_SUB, FN_SUBU: begin
            alu_out   = diff_ab[DATA_W-1:0];
            carry_out = diff_ab[DATA_W];
          end
          FN_AND:  alu_out = a & b;
          FN_OR:   alu_out = a | b;
          FN_XOR:  alu_out = a ^ b;
          FN_NOR:  alu_out = ~(a | b);
          FN_SLT:  alu_out = {{(DATA_W-1){1'b0}}, lt_ab_s};
          FN_SLTU: alu_out = {{(DATA_W-1){1'b0}}, diff_ab[DATA_W]};
          FN_JR, FN_JALR: alu_out = a;
          default: alu_out = '0;
        endcase
      end
      OP_ADDIU: begin
        alu_out   = sum_as;
        carry_out = sum_ai[DATA_W];
      end
      OP_SLTI:  alu_out = {{(DATA_W-1){1'b0}}, lt_ai_s};
      OP_SLTIU: alu_out = {{(DATA_W-1){1'b0}}, lt_ai_u};
      OP_ANDI:  alu_out = a & ze;
      OP_ORI:   alu_out = a | ze;
      OP_XORI:  alu_out = a ^ ze;
      OP_LUI:   alu_out = {imm, 16'h0000};
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SW: alu_out = sum_as;
      OP_BEQ:   branch = (a == b);
      OP_BNE:   branch = (a != b);
      OP_BLEZ:  branch = a[DATA_W-1] | (a == '0);
      OP_BGTZ:  branch = ~a[DATA_W-1] & (a != '0);
      // rt_index[0] picks BGEZ(AL) over BLTZ(AL); bit 4 (link) does not affect the test.
      OP_REGIMM: branch = rt_index[0] ? ~a[DATA_W-1] : a[DATA_W-1];
      default: begin
        alu_out   = '0;
        branch    = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

  assign zero = (alu_out == '0);

endmodule

// File: tb/tb_mips_alu_regfile.sv
// Randomized and directed bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_mips_alu_regfile;

  localparam logic [5:0] O_SP = 6'h00, O_RI = 6'h01, O_J = 6'h02, O_BEQ = 6'h04, O_BNE = 6'h05;
  localparam logic [5:0] O_BLEZ = 6'h06, O_BGTZ = 6'h07, O_ADDI = 6'h08, O_ADDIU = 6'h09;
  localparam logic [5:0] O_SLTI = 6'h0A, O_SLTIU = 6'h0B, O_ANDI = 6'h0C, O_ORI = 6'h0D;
  localparam logic [5:0] O_XORI = 6'h0E, O_LUI = 6'h0F, O_LB = 6'h20, O_LH = 6'h21, O_LWL = 6'h22;
  localparam logic [5:0] O_LW = 6'h23, O_LBU = 6'h24, O_LHU = 6'h25, O_LWR = 6'h26;
  localparam logic [5:0] O_SB = 6'h28, O_SH = 6'h29, O_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

  localparam int K_RS = 0, K_RT = 1, K_V0 = 2, K_ALU = 3, K_BR = 4, K_CY = 5, K_ZR = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [4:0]  rs_index = '0;
  logic [4:0]  rt_index = '0;
  logic [4:0]  write_index = '0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] rs_data, rt_data, alu_out, register_v0;
  logic        branch, carry_out, zero;

  always #5 clk = ~clk;

  mips_alu_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .shamt        (shamt),
    .imm          (imm),
    .rs_index     (rs_index),
    .rt_index     (rt_index),
    .write_index  (write_index),
    .write_enable (write_enable),
    .write_data   (write_data),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_out      (alu_out),
    .branch       (branch),
    .carry_out    (carry_out),
    .zero         (zero),
    .register_v0  (register_v0)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] mregs[32];
  logic        pend_we = 1'b0;
  logic [4:0]  pend_wi = '0;
  logic [31:0] pend_wd = '0;

  logic [5:0] op_list [26] = '{O_SP, O_SP, O_SP, O_SP, O_RI, O_J, O_BEQ, O_BNE, O_BLEZ, O_BGTZ,
                               O_ADDI, O_ADDIU, O_SLTI, O_SLTIU, O_ANDI, O_ORI, O_XORI, O_LUI,
                               O_LB, O_LH, O_LWL, O_LW, O_LBU, O_LWR, O_SB, O_SW};
  logic [5:0] fn_list [20] = '{F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR,
                               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                               F_SLT, F_SLTU, 6'h18, 6'h10};

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RS:    return rs_data;
      K_RT:    return rt_data;
      K_V0:    return register_v0;
      K_ALU:   return alu_out;
      K_BR:    return {31'b0, branch};
      K_CY:    return {31'b0, carry_out};
      default: return {31'b0, zero};
    endcase
  endfunction

  // Monitor: outputs are combinational, so everything queued this cycle is due at the negedge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      chk_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (actual(e.kind) === e.exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", e.name, actual(e.kind), e.exp);
    end
  end

  task automatic push(input string nm, input int k, input logic [31:0] v);
    chk_t e;
    e.name = nm;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Reference model: MIPS-I semantics in plain integer arithmetic.
  function automatic void ref_alu(input logic [5:0] op, fn, input logic [4:0] sh,
                                  input logic [15:0] im, input logic [4:0] rti,
                                  input logic [31:0] a, b,
                                  output logic [31:0] r, output logic br, output logic cy);
    longint      ua, ub, use_;
    int          sa, sb, sse;
    logic [31:0] se;
    logic [63:0] t;
    se = {{16{im[15]}}, im};
    ua = a; ub = b; use_ = se;
    sa = a; sb = b; sse = se;
    r = 0; br = 0; cy = 0;
    case (op)
      O_SP: case (fn)
        F_SLL:  r = b << sh;
        F_SRL:  r = b >> sh;
        F_SRA:  r = sb >>> sh;
        F_SLLV: r = b << (ua % 32);
        F_SRLV: r = b >> (ua % 32);
        F_SRAV: r = sb >>> (ua % 32);
        F_ADD, F_ADDU: begin t = ua + ub; r = t[31:0]; cy = (t >= 64'h1_0000_0000); end
        F_SUB, F_SUBU: begin r = a - b; cy = (ua < ub); end
        F_AND:  r = a & b;
        F_OR:   r = a | b;
        F_XOR:  r = a ^ b;
        F_NOR:  r = ~(a | b);
        F_SLT:  r = (sa < sb) ? 1 : 0;
        F_SLTU: r = (ua < ub) ? 1 : 0;
        F_JR, F_JALR: r = a;
        default: r = 0;
      endcase
      O_ADDIU: begin t = ua + use_; r = t[31:0]; cy = (t >= 64'h1_0000_0000); end
      O_SLTI:  r = (sa < sse) ? 1 : 0;
      O_SLTIU: r = (ua < use_) ? 1 : 0;
      O_ANDI:  r = a & {16'h0, im};
      O_ORI:   r = a | {16'h0, im};
      O_XORI:  r = a ^ {16'h0, im};
      O_LUI:   r = {im, 16'h0};
      O_LB, O_LH, O_LWL, O_LW, O_LBU, O_LHU, O_LWR, O_SB, O_SH, O_SW: r = a + se;
      O_BEQ:   br = (a == b);
      O_BNE:   br = (a != b);
      O_BLEZ:  br = (sa <= 0);
      O_BGTZ:  br = (sa > 0);
      O_RI:    br = rti[0] ? (sa >= 0) : (sa < 0);
      default: r = 0;
    endcase
  endfunction

  task automatic step(input logic [5:0] op, fn, input logic [4:0] sh, input logic [15:0] im,
                      input logic [4:0] rs, rt, input logic we, input logic [4:0] wi,
                      input logic [31:0] wd);
    logic [31:0] r;
    logic        br, cy;
    @(posedge clk);
    if (pend_we && pend_wi != 0) mregs[pend_wi] = pend_wd;
    #1;
    reset = 1'b1;
    opcode = op; funct = fn; shamt = sh; imm = im;
    rs_index = rs; rt_index = rt;
    write_enable = we; write_index = wi; write_data = wd;
    pend_we = we; pend_wi = wi; pend_wd = wd;
    ref_alu(op, fn, sh, im, rt, mregs[rs], mregs[rt], r, br, cy);
    push("rs_data", K_RS, mregs[rs]);
    push("rt_data", K_RT, mregs[rt]);
    push("register_v0", K_V0, mregs[2]);
    push("alu_out", K_ALU, r);
    push("branch", K_BR, {31'b0, br});
    push("carry_out", K_CY, {31'b0, cy});
    push("zero", K_ZR, {31'b0, (r == 0)});
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    step(O_SP, F_SLL, 5'd0, 16'h0, 5'd0, 5'd0, 1'b1, idx, val);
  endtask

  task automatic exec(input logic [5:0] op, fn, input logic [4:0] sh, input logic [15:0] im,
                      input logic [4:0] rs, rt);
    step(op, fn, sh, im, rs, rt, 1'b0, 5'd0, 32'h0);
  endtask

  // Reset asserted mid-cycle with a write strobe active that must be ignored.
  task automatic rst_step(input logic [4:0] rs);
    @(posedge clk);
    if (pend_we && pend_wi != 0) mregs[pend_wi] = pend_wd;
    #1;
    write_enable = 1'b1; write_index = 5'd2; write_data = 32'hFFFF_FFFF;
    rs_index = rs;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    pend_we = 1'b0;
    #1;
    push("rst_v0", K_V0, 32'h0);
    push("rst_rs", K_RS, 32'h0);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    rst_step(5'd2);
    wr(5'd2, 32'h1234);
    exec(O_SP, F_SLL, 5'd0, 16'h0, 5'd2, 5'd0);
    push("v0_written", K_V0, 32'h1234);
    rst_step(5'd2);
    wr(5'd0, 32'hDEAD);
    exec(O_SP, F_SLL, 5'd0, 16'h0, 5'd0, 5'd0);
    push("r0_hardwired", K_RS, 32'h0);

    wr(5'd3, 32'h7FFF_FFFF);
    wr(5'd4, 32'h1);
    step(O_SP, F_ADDU, 5'd0, 16'h0, 5'd3, 5'd4, 1'b1, 5'd3, 32'hFFFF_FFFF);
    push("addu_ovf_sum", K_ALU, 32'h8000_0000);
    push("addu_ovf_cy", K_CY, 32'h0);
    exec(O_SP, F_ADDU, 5'd0, 16'h0, 5'd3, 5'd4);
    push("addu_wrap_sum", K_ALU, 32'h0);
    push("addu_wrap_cy", K_CY, 32'h1);
    push("addu_wrap_zero", K_ZR, 32'h1);

    wr(5'd5, 32'h8000_0000);
    wr(5'd9, 32'd33);
    exec(O_SP, F_SRA, 5'd31, 16'h0, 5'd0, 5'd5);
    push("sra31", K_ALU, 32'hFFFF_FFFF);
    exec(O_SP, F_SRL, 5'd31, 16'h0, 5'd0, 5'd5);
    push("srl31", K_ALU, 32'h1);
    exec(O_SP, F_SLLV, 5'd0, 16'h0, 5'd9, 5'd4);
    push("sllv33", K_ALU, 32'h2);
    exec(O_SP, F_SLL, 5'd0, 16'h0, 5'd0, 5'd5);
    push("sll0", K_ALU, 32'h8000_0000);

    wr(5'd6, 32'hFFFF_FFFF);
    wr(5'd7, 32'h1);
    wr(5'd11, 32'h5);
    wr(5'd12, 32'h1000);
    exec(O_SP, F_SLT, 5'd0, 16'h0, 5'd6, 5'd7);
    push("slt", K_ALU, 32'h1);
    exec(O_SP, F_SLTU, 5'd0, 16'h0, 5'd6, 5'd7);
    push("sltu", K_ALU, 32'h0);
    exec(O_SLTIU, 6'h0, 5'd0, 16'hFFFF, 5'd11, 5'd0);
    push("sltiu", K_ALU, 32'h1);
    exec(O_LUI, 6'h0, 5'd0, 16'hABCD, 5'd0, 5'd0);
    push("lui", K_ALU, 32'hABCD_0000);

    exec(O_BEQ, 6'h0, 5'd0, 16'h0, 5'd6, 5'd6);
    push("beq_eq", K_BR, 32'h1);
    exec(O_BGTZ, 6'h0, 5'd0, 16'h0, 5'd0, 5'd0);
    push("bgtz_0", K_BR, 32'h0);
    exec(O_BLEZ, 6'h0, 5'd0, 16'h0, 5'd0, 5'd0);
    push("blez_0", K_BR, 32'h1);
    exec(O_RI, 6'h0, 5'd0, 16'h0, 5'd0, 5'd1);
    push("bgez_0", K_BR, 32'h1);

    wr(5'd8, 32'h1111_1111);
    step(O_SP, F_SLL, 5'd0, 16'h0, 5'd8, 5'd0, 1'b1, 5'd8, 32'h2222_2222);
    push("r8_old", K_RS, 32'h1111_1111);
    exec(O_SP, F_SLL, 5'd0, 16'h0, 5'd8, 5'd0);
    push("r8_new", K_RS, 32'h2222_2222);
    exec(O_LW, 6'h0, 5'd0, 16'hFFFC, 5'd12, 5'd0);
    push("lw_addr", K_ALU, 32'h0000_0FFC);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 25)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 19)];
      step(op, fn, 5'($urandom), 16'(($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom),
           5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), rnd_data());
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
